// File: rtl/ula_pkg.sv
// Shared ULA opcode map and arbiter state encoding.
package ula_pkg;
  localparam logic [3:0] ULA_DIV = 4'b0000;
  localparam logic [3:0] ULA_MUL = 4'b0001;
  localparam logic [3:0] ULA_SUB = 4'b0010;
  localparam logic [3:0] ULA_ADD = 4'b0011;
  localparam logic [3:0] ULA_OR  = 4'b0100;
  localparam logic [3:0] ULA_AND = 4'b0101;
  localparam logic [3:0] ULA_BNE = 4'b0110;
  localparam logic [3:0] ULA_BGT = 4'b0111;
  localparam logic [3:0] ULA_BLT = 4'b1000;
  localparam logic [3:0] ULA_NOP = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone valid wins, a tie goes to the pointer.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_ptr,
  output logic       o_grant,
  output logic       o_grant_any
);
  always_comb begin
    o_grant_any = |i_valid;
    o_grant     = (i_valid == 2'b11) ? i_ptr : i_valid[1];
  end
endmodule

// File: rtl/ula_arbiter.sv
// Shares one combinational ULA between two requesters, one operation in flight.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// valid must be held until then, ready never waits on anything but the FSM state.
module ula_arbiter
  import ula_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [OPW-1:0]   req_op0,
  input  logic [OPW-1:0]   req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [OPW-1:0]   alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic [1:0]       dbg_state
);
  arb_state_t       r_state;
  logic             r_rr_ptr;
  logic             r_owner;
  logic             r_div0;
  logic [OPW-1:0]   r_alu_ctrl;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [1:0]       r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_err;

  logic             w_grant;
  logic             w_grant_any;
  logic             w_accept;
  logic             w_rsp_done;
  logic             w_div0;
  logic [OPW-1:0]   w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;

  rr_arb2 u_rr (
    .i_valid     (req_valid),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_any (w_grant_any)
  );

  always_comb begin
    w_op       = w_grant ? req_op1 : req_op0;
    w_a        = w_grant ? req_a1  : req_a0;
    w_b        = w_grant ? req_b1  : req_b0;
    w_div0     = (w_op == OPW'(ULA_DIV)) && (w_b == '0);
    w_accept   = (r_state == IDLE) && w_grant_any && !rst;
    req_ready  = w_accept ? (2'b01 << w_grant) : 2'b00;
    w_rsp_done = (r_state == RESP) && rsp_ready[r_owner];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rr_ptr     <= 1'b0;
      r_owner      <= 1'b0;
      r_div0       <= 1'b0;
      r_alu_ctrl   <= OPW'(ULA_NOP);
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_valid  <= 2'b00;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner    <= w_grant;
            r_div0     <= w_div0;
            // A zero divisor never reaches the ULA; it idles on NOP instead.
            r_alu_ctrl <= w_div0 ? OPW'(ULA_NOP) : w_op;
            r_alu_a    <= w_a;
            r_alu_b    <= w_b;
            r_state    <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_result <= r_div0 ? '0 : alu_result;
          r_rsp_zero   <= r_div0 ? 1'b1 : alu_zero;
          r_rsp_err    <= r_div0;
          r_rsp_valid  <= r_owner ? 2'b10 : 2'b01;
          r_state      <= RESP;
        end
        RESP: begin
          if (w_rsp_done) begin
            r_rsp_valid <= 2'b00;
            r_rr_ptr    <= ~r_owner;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rsp_valid  = r_rsp_valid;
    rsp_result = r_rsp_result;
    rsp_zero   = r_rsp_zero;
    rsp_err    = r_rsp_err;
    alu_ctrl   = r_alu_ctrl;
    alu_a      = r_alu_a;
    alu_b      = r_alu_b;
    dbg_state  = r_state;
  end
endmodule

// File: tb/tb_ula_arbiter.sv
// Bench for ula_arbiter: behavioural ULA, transaction-level arbiter model, scoreboard.
module tb_ula_arbiter;
  import ula_pkg::*;
  localparam int W = 32;

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } txn_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_next = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]   req_valid = '0, req_ready, rsp_valid, rsp_ready = '0, dbg_state;
  logic [3:0]   req_op0 = '0, req_op1 = '0, alu_ctrl;
  logic [W-1:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
  logic [W-1:0] rsp_result, alu_a, alu_b, alu_result;
  logic         rsp_zero, rsp_err, alu_zero;

  ula_arbiter #(.WIDTH(W), .OPW(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .dbg_state(dbg_state)
  );

  // behavioural ULA: returns {zero, result}
  function automatic logic [W:0] ula_ref(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      ULA_DIV: r = (b == 0) ? '1 : a / b;
      ULA_MUL: r = a * b;
      ULA_SUB: r = a - b;
      ULA_ADD: r = a + b;
      ULA_OR:  r = a | b;
      ULA_AND: r = a & b;
      ULA_BNE: r = (a != b) ? 0 : 1;
      ULA_BGT: r = (a > b)  ? 0 : 1;
      ULA_BLT: r = (a < b)  ? 0 : 1;
      default: r = '0;
    endcase
    return {(r == 0), r};
  endfunction

  always_comb {alu_zero, alu_result} = ula_ref(alu_ctrl, alu_a, alu_b);

  // expected response {err, zero, result} for a request
  function automatic logic [W+1:0] exp_rsp(txn_t t);
    if (t.op == ULA_DIV && t.b == 0) return {1'b1, 1'b1, {W{1'b0}}};
    return {1'b0, ula_ref(t.op, t.a, t.b)};
  endfunction

  // scoreboard and arbiter model state
  txn_t         pend0[$], pend1[$];
  logic [W+1:0] exp_q[$];
  int           grant_log[$];
  int           n_checks = 0, n_pass = 0;
  bit           m_busy = 0, m_owner = 0, m_pref = 0;
  int           m_age = 0;
  txn_t         m_txn;
  int           stall = 0;
  bit           rnd_rsp = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic sample();
    logic [1:0] exp_rv, exp_rdy, v;
    bit grant;
    exp_rv = (m_busy && m_age >= 2) ? (2'b01 << m_owner) : 2'b00;
    check("rsp_valid", rsp_valid, exp_rv);
    check("state", dbg_state, !m_busy ? 2'(IDLE) : (m_age == 1 ? 2'(EXEC) : 2'(RESP)));
    if (m_busy) begin
      check("alu_ctrl", alu_ctrl,
            (m_txn.op == ULA_DIV && m_txn.b == 0) ? ULA_NOP : m_txn.op);
      check("alu_a", alu_a, m_txn.a);
      check("alu_b", alu_b, m_txn.b);
    end
    if (exp_rv != 0 && rsp_valid == exp_rv)
      check("rsp_data", {rsp_err, rsp_zero, rsp_result}, exp_q[0]);
    v = req_valid;
    grant = (v == 2'b11) ? m_pref : v[1];
    exp_rdy = (!m_busy && !rst && v != 0) ? (2'b01 << grant) : 2'b00;
    check("req_ready", req_ready, exp_rdy);
    // advance the model across the coming edge
    if (rst) begin
      m_busy = 0; m_pref = 0; m_age = 0;
      exp_q.delete();
    end else if (m_busy) begin
      if (m_age >= 2 && rsp_ready[m_owner]) begin
        m_busy = 0;
        m_pref = ~m_owner;
        void'(exp_q.pop_front());
      end else m_age++;
    end else if (exp_rdy != 0) begin
      m_owner = grant;
      m_txn = grant ? pend1.pop_front() : pend0.pop_front();
      m_busy = 1; m_age = 1;
      exp_q.push_back(exp_rsp(m_txn));
      grant_log.push_back(int'(grant));
    end
  endtask

  // driver: one cycle
  task automatic tick();
    @(posedge clk); #1;
    rst = rst_next;
    req_valid[0] = pend0.size() != 0;
    req_valid[1] = pend1.size() != 0;
    if (req_valid[0]) begin req_op0 = pend0[0].op; req_a0 = pend0[0].a; req_b0 = pend0[0].b; end
    if (req_valid[1]) begin req_op1 = pend1[0].op; req_a1 = pend1[0].a; req_b1 = pend1[0].b; end
    if (stall > 0) begin rsp_ready = 2'b00; stall--; end
    else if (rnd_rsp) rsp_ready = 2'($urandom_range(0, 3));
    else rsp_ready = 2'b11;
    #1;
    sample();
  endtask

  task automatic push(int who, logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
    txn_t t;
    t.op = op; t.a = a; t.b = b;
    if (who == 0) pend0.push_back(t); else pend1.push_back(t);
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((pend0.size() != 0 || pend1.size() != 0 || m_busy) && n < budget) begin
      tick(); n++;
    end
    check("drain_timeout", n < budget, 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp", {rsp_err, rsp_zero, rsp_result}, '0);
    check("rst_alu_ctrl", alu_ctrl, ULA_NOP);
    check("rst_alu_ab", {alu_a, alu_b}, '0);
    check("rst_state", dbg_state, 2'(IDLE));
  endtask

  task automatic do_reset();
    rst_next = 1; tick(); tick();
    check_reset_outputs();
    rst_next = 0;
  endtask

  initial begin
    int n;
    do_reset();

    // single add, latency enforced cycle by cycle by the model
    push(0, ULA_ADD, 5, 7);
    drain(20);

    // contention from reset: 6 alternating grants
    do_reset();
    grant_log.delete();
    push(0, ULA_SUB, 9, 9);      push(1, ULA_OR, 32'hF0, 32'h0F);
    push(0, ULA_ADD, 1, 2);      push(1, ULA_AND, 32'hFF, 32'h3C);
    push(0, ULA_MUL, 3, 4);      push(1, ULA_SUB, 2, 5);
    drain(60);
    check("grant_count", grant_log.size(), 6);
    for (int i = 0; i < grant_log.size(); i++)
      check($sformatf("grant%0d", i), grant_log[i], i % 2);

    // divide by zero then a legal divide
    push(1, ULA_DIV, 10, 0);
    push(1, ULA_DIV, 10, 3);
    drain(30);

    // response backpressure with the other requester waiting
    grant_log.delete();
    push(0, ULA_MUL, 6, 7);
    push(1, ULA_ADD, 1, 1);
    stall = 7;
    drain(40);
    check("bp_order0", grant_log[0], 0);
    check("bp_order1", grant_log[1], 1);

    // reset during EXEC drops the operation and clears the pointer
    push(0, ULA_ADD, 2, 2);
    drain(20);
    push(0, ULA_AND, 32'hFF, 32'h0F);
    n = 0;
    while (!m_busy && n < 20) begin tick(); n++; end
    check("wait_accept", m_busy, 1);
    rst_next = 1;
    tick();
    tick();
    check_reset_outputs();
    rst_next = 0;
    grant_log.delete();
    push(0, ULA_ADD, 1, 0); push(1, ULA_ADD, 0, 1);
    drain(30);
    check("post_rst_grant", grant_log[0], 0);

    // branch compares
    push(0, ULA_BGT, 3, 2);
    push(0, ULA_BLT, 3, 2);
    drain(30);

    // randomized traffic with random response backpressure
    rnd_rsp = 1;
    for (int i = 0; i < 80; i++) begin
      push(int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom),
           ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 1000)));
      tick();
    end
    drain(2000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ula_arbiter.md
# ula_arbiter

Shares the single combinational ULA between two requesters (e.g. the main EX stage and a secondary unit such as a branch comparator or multi-cycle helper). Each requester issues operations through a valid/ready request channel; the arbiter grants round-robin, drives the ULA from registered operands, captures the result and zero flag, and returns them on a per-requester valid/ready response channel. At most one operation is in flight at any time.

## Interface
- WIDTH, 32, operand/result width
- OPW, 4, ULA control width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid[1:0]  in  2  request i present
- req_ready[1:0]  out  2  request i accepted this cycle
- req_op0 / req_op1  in  OPW  ULA control code per requester
- req_a0 / req_a1, req_b0 / req_b1  in  WIDTH  operands per requester
- rsp_valid[1:0]  out  2  response for requester i held
- rsp_ready[1:0]  in  2  requester i consumes response
- rsp_result  out  WIDTH  shared result bus, meaningful for the rsp_valid owner
- rsp_zero  out  1  ULA zero flag captured with result
- rsp_err  out  1  divide-by-zero flag
- alu_ctrl  out  OPW  to ULA ALU_Control
- alu_a, alu_b  out  WIDTH  to ULA inA/inB
- alu_result  in  WIDTH  from ULA result
- alu_zero  in  1  from ULA zero

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: grant = requester with req_valid; if both valid, grant = rr_ptr. req_ready[grant]=1 combinationally, other bit 0. On handshake: latch op/a/b into alu_ctrl/alu_a/alu_b, latch owner, go EXEC. No valid: stay IDLE.
- EXEC: one settle cycle. At the end of the cycle capture rsp_result<=alu_result, rsp_zero<=alu_zero; go RESP.
- Divide-by-zero: op 4'b0000 with b==0 -> ULA is not driven with the divide; alu_ctrl is loaded with NOP 4'b1111 instead, rsp_result=0, rsp_zero=1, rsp_err=1. Otherwise rsp_err=0.
- RESP: rsp_valid[owner]=1; hold rsp_result/zero/err and alu_* stable until rsp_ready[owner]. On handshake: rr_ptr<=~owner, go IDLE. rsp_ready of the non-owner ignored.
- Opcodes 4'b1001–4'b1111 forwarded unchanged (ULA returns 0, zero=1); no error.
- req_ready is 0 in EXEC and RESP; requests wait with valid held.

## Timing
- Reset values: state=IDLE, rr_ptr=0, req_ready=0 (until IDLE evaluates valids, combinational), rsp_valid=2'b00, rsp_result=0, rsp_zero=0, rsp_err=0, alu_ctrl=4'b1111, alu_a=alu_b=0.
- Accept at cycle T -> rsp_valid at T+2 (earliest rsp handshake T+2). Next accept earliest T+3; back-to-back throughput one op per 3 cycles.
- No accept in the same cycle as a response handshake.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1...
- Reset mid-operation (EXEC or RESP): operation dropped, no response emitted, all outputs to reset values next cycle.
- Request valid dropped before acceptance: no grant, no state change (requesters must not do this, but arbiter tolerates it).

## Structure
- Shared package ula_pkg: opcode constants ULA_DIV=4'b0000, ULA_MUL=0001, ULA_SUB=0010, ULA_ADD=0011, ULA_OR=0100, ULA_AND=0101, ULA_BNE=0110, ULA_BGT=0111, ULA_BLT=1000, ULA_NOP=4'b1111; state enum {IDLE,EXEC,RESP}.
- One sub-module: rr_arb2 (2-way round-robin picker: valid[1:0], ptr -> grant index, grant_any), combinational.
- ULA instantiated outside; arbiter only drives/receives its ports.

## Test plan
- Reset, then req0: op ADD a=5 b=7 -> req_ready[0] at T, rsp_valid[0] at T+2, rsp_result=12, rsp_zero=0, rsp_err=0.
- Both valid from reset: req0 SUB 9-9, req1 OR 0xF0|0x0F -> first grant 0 (result 0, zero=1), then grant 1 (result 0xFF); with continuous valids grants alternate for 6 ops.
- req1 DIV a=10 b=0 -> alu_ctrl=4'b1111 during op, rsp_result=0, rsp_zero=1, rsp_err=1; following req1 DIV 10/3 -> 3, err=0.
- Backpressure: req0 MUL 6*7, rsp_ready[0]=0 for 5 cycles -> rsp_valid[0], result 42 and alu_* held stable; req1 pending sees req_ready[1]=0 throughout; granted the cycle after rsp handshake+1.
- Reset asserted in EXEC of req0 AND 0xFF&0x0F -> no rsp_valid ever asserted for it; outputs at reset values; rr_ptr=0.
- req0 BGT a=3 b=2 -> result 0, zero=1; BLT a=3 b=2 -> result 1, zero=0.
